// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encoding and requester port identifiers shared by the arbiter.
package ram_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    RESPOND
  } state_t;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;
endpackage

// File: rtl/ram_arbiter_watchdog.sv
// ram_arbiter_watchdog: saturating cycle counter that flags a transaction the controller never finishes.
module ram_arbiter_watchdog
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : (run && count_q != LIMIT) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  // The trigger cycle is the first counted, so expiry lands TIMEOUT_CYCLES after it.
  assign expired = run && (count_d == LIMIT);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM controller port between fetch (port 0) and load/store (port 1).
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to port 1.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 28,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE / 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  output logic                    p0_gnt,
  input  logic                    p0_we,
  input  logic [ADDRESS_SIZE-1:0] p0_addr,
  input  logic [MASK_SIZE-1:0]    p0_mask,
  input  logic [DATA_SIZE-1:0]    p0_wdata,
  output logic                    p0_done,
  output logic [DATA_SIZE-1:0]    p0_rdata,
  output logic                    p0_err,
  input  logic                    p1_req,
  output logic                    p1_gnt,
  input  logic                    p1_we,
  input  logic [ADDRESS_SIZE-1:0] p1_addr,
  input  logic [MASK_SIZE-1:0]    p1_mask,
  input  logic [DATA_SIZE-1:0]    p1_wdata,
  output logic                    p1_done,
  output logic [DATA_SIZE-1:0]    p1_rdata,
  output logic                    p1_err,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [MASK_SIZE-1:0]    ram_mask,
  output logic [DATA_SIZE-1:0]    ram_write_value,
  output logic                    ram_write_trigger,
  output logic                    ram_read_trigger,
  input  logic                    ram_controller_ready,
  input  logic [3:0]              ram_error,
  input  logic [DATA_SIZE-1:0]    ram_read_value,
  input  logic                    ram_read_value_ready
);
  state_t state_q, state_d;
  logic owner_q, owner_d, we_q, we_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [MASK_SIZE-1:0] mask_q, mask_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d, rdata_q, rdata_d, resp_data;
  logic rvalid_seen_q, rvalid_seen_d, timeout_q, timeout_d;
  logic sel, handshake, fire, waiting, expired, resp_err;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q;
  assign sel = (p0_req && p1_req) ? !last_grant_q : p1_req;
  always_ff @(posedge clk) last_grant_q <= reset ? PORT_LSU : handshake ? sel : last_grant_q;
`else
  assign sel = p1_req;
`endif
  assign p0_gnt = (state_q == IDLE) && p0_req && (sel == PORT_FETCH);
  assign p1_gnt = (state_q == IDLE) && p1_req && (sel == PORT_LSU);
  assign handshake = p0_gnt || p1_gnt;
  assign fire = (state_q == ISSUE) && ram_controller_ready;
  assign waiting = (state_q == WAIT_ACCEPT) || (state_q == WAIT_DONE);
  assign ram_read_trigger = fire && !we_q;
  assign ram_write_trigger = fire && we_q;
  assign ram_address = addr_q;
  assign ram_mask = mask_q;
  assign ram_write_value = wdata_q;
  ram_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (fire || waiting),
    .clear  (state_q == IDLE),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    mask_d = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rvalid_seen_d = rvalid_seen_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (handshake) begin
        state_d = ISSUE;
        owner_d = sel;
        we_d = sel ? p1_we : p0_we;
        addr_d = sel ? p1_addr : p0_addr;
        mask_d = sel ? p1_mask : p0_mask;
        wdata_d = sel ? p1_wdata : p0_wdata;
      end
      ISSUE: if (fire) begin
        state_d = WAIT_ACCEPT;
        rvalid_seen_d = 1'b0;
        timeout_d = 1'b0;
        rdata_d = '0;
      end
      WAIT_ACCEPT: begin
        state_d = expired ? RESPOND : !ram_controller_ready ? WAIT_DONE : WAIT_ACCEPT;
        timeout_d = expired;
      end
      WAIT_DONE: begin
        if (ram_read_value_ready) begin
          rdata_d = ram_read_value;
          rvalid_seen_d = 1'b1;
        end
        // Normal completion outranks a watchdog expiry landing on the same cycle.
        if (ram_controller_ready && (we_q || rvalid_seen_q || ram_read_value_ready)) state_d = RESPOND;
        else if (expired) begin
          state_d = RESPOND;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= PORT_FETCH;
      we_q <= 1'b0;
      addr_q <= '0;
      mask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvalid_seen_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvalid_seen_q <= rvalid_seen_d;
      timeout_q <= timeout_d;
    end
  end
  assign resp_data = (we_q || timeout_q) ? '0 : rdata_q;
  assign resp_err = timeout_q || (ram_error != 4'd0);
  assign p0_done = (state_q == RESPOND) && (owner_q == PORT_FETCH);
  assign p1_done = (state_q == RESPOND) && (owner_q == PORT_LSU);
  assign p0_rdata = p0_done ? resp_data : '0;
  assign p1_rdata = p1_done ? resp_data : '0;
  assign p0_err = p0_done && resp_err;
  assign p1_err = p1_done && resp_err;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural RAM controller model.
module tb_ram_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset;
  logic p0_req, p0_gnt, p0_we, p0_done, p0_err;
  logic p1_req, p1_gnt, p1_we, p1_done, p1_err;
  logic [AW-1:0] p0_addr, p1_addr, ram_address;
  logic [MW-1:0] p0_mask, p1_mask, ram_mask;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_write_value, ram_read_value;
  logic ram_write_trigger, ram_read_trigger, ram_controller_ready, ram_read_value_ready;
  logic [3:0] ram_error;
  always #5 clk = ~clk;
  ram_arbiter #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MASK_SIZE(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_we(p0_we), .p0_addr(p0_addr), .p0_mask(p0_mask),
    .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_we(p1_we), .p1_addr(p1_addr), .p1_mask(p1_mask),
    .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_address(ram_address), .ram_mask(ram_mask), .ram_write_value(ram_write_value),
    .ram_write_trigger(ram_write_trigger), .ram_read_trigger(ram_read_trigger),
    .ram_controller_ready(ram_controller_ready), .ram_error(ram_error),
    .ram_read_value(ram_read_value), .ram_read_value_ready(ram_read_value_ready)
  );
  typedef struct packed {
    logic port;
    logic [DW-1:0] rdata;
    logic err;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, rd_trig = 0, wr_trig = 0, done_cnt = 0;
  int t_hs = 0, t_trig = 0, t_done = 0;
  bit hs_seen = 0;
  logic hs_port = 0;
  int ctl_lat = 1;
  bit ctl_hang = 0, ctl_early = 0, hold_busy = 0;
  logic [DW-1:0] ctl_data = '0;
  // Controller model: drops ready the cycle after a trigger, finishes ctl_lat cycles later.
  initial begin
    bit fire, rd, pending, is_rd;
    int cnt;
    pending = 0;
    is_rd = 0;
    cnt = 0;
    ram_controller_ready = 1'b1;
    ram_read_value_ready = 1'b0;
    ram_read_value = '0;
    forever begin
      @(negedge clk);
      fire = ram_read_trigger || ram_write_trigger;
      rd = ram_read_trigger;
      @(posedge clk);
      #2;
      ram_read_value_ready = 1'b0;
      if (fire) begin
        pending = 1;
        cnt = ctl_lat;
        is_rd = rd;
      end else if (pending && !ctl_hang) begin
        cnt--;
        if (cnt == 0) begin
          pending = 0;
          ram_read_value_ready = is_rd && !ctl_early;
        end else if (cnt == 1 && ctl_early && is_rd) ram_read_value_ready = 1'b1;
      end
      ram_read_value = ram_read_value_ready ? ctl_data : 32'hBAD0_BAD0;
      ram_controller_ready = !pending && !hold_busy;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic observe();
    exp_t e;
    cyc++;
    if (ram_read_trigger) rd_trig++;
    if (ram_write_trigger) wr_trig++;
    if (ram_read_trigger || ram_write_trigger) t_trig = cyc;
    if ((p0_req && p0_gnt) || (p1_req && p1_gnt)) begin
      hs_seen = 1;
      hs_port = p1_gnt;
      t_hs = cyc;
    end
    if (p0_done || p1_done) begin
      done_cnt++;
      t_done = cyc;
      chk("single_done", {p0_done, p1_done} == 2'b11, 0);
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_port", p1_done, e.port);
        chk("rdata", p1_done ? p1_rdata : p0_rdata, e.rdata);
        chk("err", p1_done ? p1_err : p0_err, e.err);
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit port, input bit we, input logic [AW-1:0] a,
                       input logic [MW-1:0] m, input logic [DW-1:0] d);
    if (port) begin
      p1_req = 1; p1_we = we; p1_addr = a; p1_mask = m; p1_wdata = d;
    end else begin
      p0_req = 1; p0_we = we; p0_addr = a; p0_mask = m; p0_wdata = d;
    end
  endtask
  task automatic await_hs();
    int k = 0;
    while (!hs_seen && k < 50) begin
      step();
      k++;
    end
    chk("grant_seen", hs_seen, 1);
    p0_req = 0;
    p1_req = 0;
  endtask
  task automatic request(input bit port, input bit we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d, input logic [DW-1:0] er, input logic ee);
    exp_q.push_back('{port: port, rdata: er, err: ee});
    hs_seen = 0;
    drive(port, we, a, m, d);
    await_hs();
  endtask
  task automatic wait_done(input int target, input int limit);
    int k = 0;
    while (done_cnt < target && k < limit) begin
      step();
      k++;
    end
    chk("done_arrived", done_cnt >= target, 1);
  endtask
  task automatic pulse_reset();
    reset = 1;
    step();
    reset = 0;
    exp_q.delete();
  endtask
  initial begin
    int d0, r0, w0, k;
    logic exp_port;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_mask = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_mask = '0; p1_wdata = '0;
    ram_error = 4'd0;
    reset = 1;
    repeat (3) step();
    reset = 0;
    chk("reset_ctl", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, ram_read_trigger, ram_write_trigger}, 0);
    chk("reset_bus", {ram_address, ram_mask, ram_write_value}, 0);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
    // p0 read, data 10 cycles after the trigger
    ctl_lat = 9; ctl_data = 32'hDEADBEEF;
    d0 = done_cnt; r0 = rd_trig; w0 = wr_trig;
    request(0, 0, 28'h100, 4'hF, '0, 32'hDEADBEEF, 0);
    wait_done(d0 + 1, 60);
    repeat (3) step();
    chk("rd_trigger_once", rd_trig - r0, 1);
    chk("rd_no_wr_trigger", wr_trig - w0, 0);
    chk("rd_done_once", done_cnt - d0, 1);
    chk("rd_latency", t_done - t_hs, 12);
    // read data arriving before ready re-rises must be held
    ctl_lat = 4; ctl_early = 1; ctl_data = 32'hCAFEF00D;
    d0 = done_cnt;
    request(0, 0, 28'h104, 4'hF, '0, 32'hCAFEF00D, 0);
    wait_done(d0 + 1, 40);
    ctl_early = 0;
    // p1 write at minimum latency with held command fields
    ctl_lat = 1;
    d0 = done_cnt; w0 = wr_trig; r0 = rd_trig;
    request(1, 1, 28'h200, 4'b0011, 32'h12345678, '0, 0);
    step();
    chk("wr_bus_mid", {ram_address, ram_mask, ram_write_value}, {28'h200, 4'b0011, 32'h12345678});
    wait_done(d0 + 1, 40);
    chk("wr_bus_done", {ram_address, ram_mask, ram_write_value}, {28'h200, 4'b0011, 32'h12345678});
    chk("wr_trigger_once", wr_trig - w0, 1);
    chk("wr_no_rd_trigger", rd_trig - r0, 0);
    chk("wr_latency", t_done - t_hs, 4);
    // simultaneous requests from a fresh reset
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      exp_port = i[0];
`else
      exp_port = 1'b1;
`endif
      d0 = done_cnt;
      exp_q.push_back('{port: exp_port, rdata: '0, err: 1'b0});
      hs_seen = 0;
      drive(0, 1, 28'h300 + AW'(i), 4'hF, 32'h1000 + i);
      drive(1, 1, 28'h380 + AW'(i), 4'hF, 32'h2000 + i);
      await_hs();
      chk("arb_grant", hs_port, exp_port);
      wait_done(d0 + 1, 40);
    end
    // controller never re-raises ready: watchdog abort
    ctl_hang = 1;
    d0 = done_cnt;
    request(0, 0, 28'h400, 4'hF, '0, '0, 1);
    wait_done(d0 + 1, 100);
    chk("timeout_latency", t_done - t_trig, TO);
    ctl_hang = 0;
    repeat (5) step();
    ctl_lat = 2; ctl_data = 32'h55AA_33CC;
    d0 = done_cnt;
    request(1, 0, 28'h404, 4'hF, '0, 32'h55AA_33CC, 0);
    wait_done(d0 + 1, 40);
    // controller busy at grant, error reported on completion
    hold_busy = 1; ram_error = 4'd1; ctl_lat = 1;
    d0 = done_cnt; w0 = wr_trig;
    request(0, 1, 28'h500, 4'hF, 32'hA5A5A5A5, '0, 1);
    repeat (5) step();
    chk("busy_no_trigger", wr_trig - w0, 0);
    hold_busy = 0;
    wait_done(d0 + 1, 40);
    chk("busy_trigger_once", wr_trig - w0, 1);
    ram_error = 4'd0;
    // reset while waiting for the controller
    ctl_lat = 9; ctl_data = 32'h0;
    d0 = done_cnt; r0 = rd_trig;
    request(1, 0, 28'h600, 4'hF, '0, '0, 0);
    k = 0;
    while (rd_trig == r0 && k < 20) begin
      step();
      k++;
    end
    chk("rst_trigger_seen", rd_trig - r0, 1);
    repeat (3) step();
    pulse_reset();
    chk("rst_ctl", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, ram_read_trigger, ram_write_trigger}, 0);
    chk("rst_bus", {ram_address, ram_mask, ram_write_value}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    repeat (4) step();
    chk("rst_no_done", done_cnt - d0, 0);
    ctl_lat = 3; ctl_data = 32'h0BAD_CAFE;
    request(0, 0, 28'h700, 4'hF, '0, 32'h0BAD_CAFE, 0);
    wait_done(d0 + 1, 60);
    repeat (3) step();
    chk("post_rst_done_once", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares the single DDR3 RAM controller port between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Accepts one transaction at a time and latches its fields.
- Issues one trigger pulse into the RAM controller, then tracks the controller's ready/read-valid handshake through completion.
- Returns data, a done pulse and an error flag to the owning requester; a watchdog aborts transactions the controller never finishes.

## Interface
Parameters:
- ADDRESS_SIZE, 28, byte address width (matches RAM controller)
- DATA_SIZE, 32, data width
- MASK_SIZE, DATA_SIZE/8, byte-enable width
- TIMEOUT_CYCLES, 4096, max cycles from trigger to completion before abort

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (RAM controller user-side clock)
- reset  in  1  synchronous active-high reset
- pN_req  in  1  request valid, N∈{0,1}
- pN_gnt  out  1  request accepted this cycle (req && gnt = handshake)
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDRESS_SIZE  address
- pN_mask  in  MASK_SIZE  byte enables
- pN_wdata  in  DATA_SIZE  write data
- pN_done  out  1  one-cycle completion pulse
- pN_rdata  out  DATA_SIZE  read data, valid with pN_done
- pN_err  out  1  error, valid with pN_done
- ram_address / ram_mask / ram_write_value  out  ADDRESS_SIZE / MASK_SIZE / DATA_SIZE  to controller, held stable for the whole transaction
- ram_write_trigger, ram_read_trigger  out  1  one-cycle command pulses
- ram_controller_ready  in  1  controller idle
- ram_error  in  4  controller error code
- ram_read_value  in  DATA_SIZE  controller read data
- ram_read_value_ready  in  1  read data valid pulse

## Operation
FSM states: IDLE → ISSUE → WAIT_ACCEPT → WAIT_DONE → RESPOND → IDLE.

- **IDLE**
  - pN_gnt is combinational: asserted only in IDLE, for the selected requesting port.
  - On handshake: latch owner, we, addr, mask, wdata; go to ISSUE.
- **ISSUE**
  - If ram_controller_ready: pulse ram_read_trigger or ram_write_trigger for exactly one cycle; clear rvalid_seen; start watchdog; go to WAIT_ACCEPT.
  - Otherwise wait; watchdog is not yet running.
- **WAIT_ACCEPT**
  - Stay until ram_controller_ready == 0, then go to WAIT_DONE.
- **WAIT_DONE**
  - On ram_read_value_ready: capture ram_read_value and set rvalid_seen.
  - Complete when ram_controller_ready == 1 and (write, or rvalid_seen, or ram_read_value_ready this cycle); go to RESPOND.
- **RESPOND**
  - Pulse owner's pN_done. pN_err = (ram_error != 0).
  - pN_rdata = captured data on reads, 0 on writes.
  - Go to IDLE. The other port's done stays 0.
- **Watchdog**
  - Counts every cycle in WAIT_ACCEPT/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: go to RESPOND with err=1, rdata=0.
- **Arbitration:** default fixed priority, port 1 over port 0 (see Configuration).
- **Requester contract:**
  - Requester may drop req or present the next request after gnt.
  - No further grant to any port until the current RESPOND has completed.

## Timing
- Reset values: pN_gnt=0, pN_done=0, pN_rdata=0, pN_err=0, ram_*_trigger=0, ram_address/mask/write_value=0, state=IDLE, watchdog=0.
- Minimum latency from handshake (cycle 0) to done:
  - read: 4 cycles plus controller time
  - write: 4 cycles
- Triggers are never asserted outside ISSUE; at most one trigger per grant.
- Simultaneous ram_read_value_ready and ram_controller_ready rise in WAIT_DONE completes in the same cycle (data taken from the live input).
- Reset mid-transaction:
  - Abandons the transaction; no done is issued.
  - After reset the FSM waits in ISSUE for ram_controller_ready, since the controller itself has no reset.
- Watchdog width: $clog2(TIMEOUT_CYCLES+1); saturates, no wrap.

## Configuration
- RAM_ARBITER_ROUND_ROBIN_EN defined: round-robin arbitration.
  - On simultaneous requests, grant the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - A lone requester is always granted.
- Undefined: fixed priority, port 1 always wins ties; no last_grant register.

## Structure
- ram_arbiter_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESPOND)
  - port-id constants PORT_FETCH=0, PORT_LSU=1
- One sub-module, ram_arbiter_watchdog, with ports clk, reset, run, clear, TIMEOUT_CYCLES parameter and expired output.

## Test plan
- p0 read addr 0x100; model asserts read_value_ready with 0xDEADBEEF 10 cycles after trigger → exactly one ram_read_trigger pulse, p0_done once, p0_rdata=0xDEADBEEF, p0_err=0.
- p1 write addr 0x200, mask 4'b0011, wdata 0x12345678 → ram_write_trigger pulse; ram_address/mask/value held until done; p1_done once, p1_err=0.
- p0 and p1 request in the same cycle, repeated 4 times:
  - fixed: grants 1,1,1,1
  - with RAM_ARBITER_ROUND_ROBIN_EN: grants 0,1,0,1
- Controller ready never re-rises, TIMEOUT_CYCLES=16 → done exactly 16 cycles after trigger, err=1, rdata=0; next request is then served normally.
- ram_controller_ready low at grant for 5 cycles → trigger delayed until ready=1; ram_error=1 during completion → err=1.
- Reset asserted in WAIT_DONE → all outputs at reset values the next cycle, no done pulse; a following request completes correctly.
